wb_downsizer: RTL
=================

# wb_downsizer

Wishbone data-width down-converter for the wb_intercon fabric. Its wide slave port faces a DW_IN-bit master. Its narrow master port faces a DW_IN/SCALE-bit slave. Each wide access is split into up to SCALE sequential classic narrow accesses, one per narrow lane whose byte selects are non-zero, and the block returns a single registered ack, err or rty to the wide side.

## Interface
- DW_IN, default 64: wide (slave-port) data width. A multiple of 8·SCALE.
- SCALE, default 2: width ratio, a power of two ≥ 2. Narrow width DW_OUT = DW_IN/SCALE, narrow sel width SW_OUT = DW_OUT/8.
- AW, default 32: byte address width.
- wb_clk_i  in  1  the only clock. All logic runs on its rising edge.
- wb_rst_i  in  1  reset. Asynchronous, active-high.
- wbs_adr_i, wbs_dat_i, wbs_sel_i, wbs_we_i, wbs_cyc_i, wbs_stb_i  in  AW, DW_IN, DW_IN/8, 1, 1, 1  wide request.
- wbs_cti_i, wbs_bte_i  in  3, 2  accepted and ignored. Every wide beat is handled as classic.
- wbs_dat_o, wbs_ack_o, wbs_err_o, wbs_rty_o  out  DW_IN, 1, 1, 1  wide response, all registered.
- wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o  out  AW, DW_OUT, SW_OUT, 1, 1, 1  narrow request, all registered.
- wbm_cti_o, wbm_bte_o  out  3, 2  constant 3'b000 and 2'b00.
- wbm_dat_i, wbm_ack_i, wbm_err_i, wbm_rty_i  in  DW_OUT, 1, 1, 1  narrow response.

## Operation
- States: S_IDLE, S_ACCESS, S_RESP.
- Lane mapping is little-endian. Lane k covers wide data bits [k·DW_OUT +: DW_OUT] and sel bits [k·SW_OUT +: SW_OUT].
- Lane address = base + k·SW_OUT, where base is wbs_adr_i with its low log2(DW_IN/8) bits cleared.
- S_IDLE, when wbs_cyc_i & wbs_stb_i:
  - Latch base, dat, sel and we.
  - Clear the read buffer.
  - If the lowest lane with non-zero sel exists, load it onto the wbm_* outputs, raise wbm_cyc_o and wbm_stb_o, and go to S_ACCESS.
  - If sel is all zero, go to S_RESP with an ack and make no narrow access.
- S_ACCESS, on wbm_ack_i:
  - If read, store wbm_dat_i into the buffer at the current lane.
  - Find the next higher lane with non-zero sel. If one exists, present it on the next cycle with wbm_stb_o held high.
  - If none remains, drop wbm_cyc_o and wbm_stb_o and go to S_RESP with an ack.
- S_ACCESS, on wbm_err_i or wbm_rty_i (priority err > rty > ack):
  - Drop the narrow cycle, skip the remaining lanes, and go to S_RESP with err or rty.
- S_ACCESS, if wbs_cyc_i deasserts:
  - Drop wbm_cyc_o and wbm_stb_o on the next edge and go to S_IDLE.
  - No wide response is given. A wbm_ack_i in that cycle is ignored.
- S_RESP:
  - Assert exactly one of wbs_ack_o, wbs_err_o or wbs_rty_o for one cycle.
  - wbs_dat_o = the buffer. Lanes that were skipped or never accessed read as 0.
  - Go to S_IDLE.
- S_IDLE does not accept a new request in the cycle it is entered from S_RESP. The request is re-sampled there on the following cycle.
- wbs_dat_o holds its value until the next request is latched. It is only meaningful while wbs_ack_o is high on a read.

## Timing
- Async reset: state = S_IDLE. Every registered output goes to 0: wbs_dat_o, wbs_ack_o, wbs_err_o, wbs_rty_o, wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o.
- Reset asserted mid-operation drops the narrow cycle immediately, with no wide response.
- Cycle numbering: cycle 0 is the cycle in which the request is seen in S_IDLE.
  - Narrow stb first appears in cycle 1.
  - With a zero-wait narrow slave (ack in the same cycle as stb), lane n is presented in cycle 1+n.
- Wide response arrives one cycle after the last narrow ack, err or rty. For N active lanes with zero-wait acks, the wide ack is in cycle N+1.
- All-zero sel: wide ack in cycle 1.
- Each narrow wait state adds exactly one cycle.
- Narrow outputs are stable while stb is high and the beat is unacknowledged.

## Test plan
- Write, DW_IN=64, SCALE=2, adr 0x100, dat 0x1122334455667788, sel 0xFF, zero-wait slave:
  - cycle 1: narrow write adr 0x100, dat 0x55667788, sel 0xF.
  - cycle 2: narrow write adr 0x104, dat 0x11223344, sel 0xF.
  - cycle 3: wbs_ack_o high.
- Write with sel 0xF0 at adr 0x108 -> single narrow write at adr 0x10C, sel 0xF, dat = upper word; wbs_ack_o in cycle 2.
- Read at adr 0x200, sel 0xFF, slave returns 0xAAAA0000 after 2 wait states, then 0xBBBB1111 with zero wait -> wbs_dat_o = 0xBBBB1111AAAA0000 with wbs_ack_o in cycle 5.
- Read with sel 0x0F -> one narrow read at the base address; wbs_dat_o[63:32] = 0.
- wbm_err_i on lane 0 of a two-lane write -> lane 1 is never issued; wbs_err_o high for one cycle in cycle 2; wbs_ack_o stays 0.
- All-zero sel -> no wbm_cyc_o, wbs_ack_o in cycle 1.
- wb_rst_i pulsed while lane 1 is outstanding -> wbm_cyc_o = 0 immediately; no wide response; a new request afterwards completes normally.

Source files
------------

// File: rtl/wb_downsizer.sv
// Wishbone width down-converter: splits each wide classic access into one narrow
// classic access per lane with non-zero byte selects, then returns one wide response.
module wb_downsizer #(
  parameter int DW_IN = 64,
  parameter int SCALE = 2,
  parameter int AW    = 32
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic [AW-1:0]           wbs_adr_i,
  input  logic [DW_IN-1:0]        wbs_dat_i,
  input  logic [DW_IN/8-1:0]      wbs_sel_i,
  input  logic                    wbs_we_i,
  input  logic                    wbs_cyc_i,
  input  logic                    wbs_stb_i,
  input  logic [2:0]              wbs_cti_i,
  input  logic [1:0]              wbs_bte_i,
  output logic [DW_IN-1:0]        wbs_dat_o,
  output logic                    wbs_ack_o,
  output logic                    wbs_err_o,
  output logic                    wbs_rty_o,
  output logic [AW-1:0]           wbm_adr_o,
  output logic [DW_IN/SCALE-1:0]  wbm_dat_o,
  output logic [DW_IN/SCALE/8-1:0] wbm_sel_o,
  output logic                    wbm_we_o,
  output logic                    wbm_cyc_o,
  output logic                    wbm_stb_o,
  output logic [2:0]              wbm_cti_o,
  output logic [1:0]              wbm_bte_o,
  input  logic [DW_IN/SCALE-1:0]  wbm_dat_i,
  input  logic                    wbm_ack_i,
  input  logic                    wbm_err_i,
  input  logic                    wbm_rty_i
);
  localparam int DW_OUT = DW_IN / SCALE;
  localparam int SW_IN  = DW_IN / 8;
  localparam int SW_OUT = DW_OUT / 8;
  localparam int LW     = $clog2(SCALE);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  // Lowest lane >= start with any sel bit set; MSB of the result flags "none left".
  function automatic logic [LW:0] next_lane(input logic [SW_IN-1:0] sel, input int start);
    logic [LW:0] r;
    r = (LW+1)'(SCALE);
    for (int k = SCALE - 1; k >= 0; k--) begin
      if (k >= start && |sel[k*SW_OUT +: SW_OUT]) r = (LW+1)'(k);
    end
    return r;
  endfunction

  state_t             state_q, state_d;
  logic [AW-1:0]      base_q, base_d;
  logic [DW_IN-1:0]   dat_q, dat_d;
  logic [SW_IN-1:0]   sel_q, sel_d;
  logic               we_q, we_d;
  logic [LW-1:0]      lane_q, lane_d;
  logic [DW_IN-1:0]   buf_q, buf_d;
  logic               hold_q, hold_d;
  logic               ack_q, ack_d, err_q, err_d, rty_q, rty_d;
  logic [AW-1:0]      wbm_adr_q, wbm_adr_d;
  logic [DW_OUT-1:0]  wbm_dat_q, wbm_dat_d;
  logic [SW_OUT-1:0]  wbm_sel_q, wbm_sel_d;
  logic               wbm_we_q, wbm_we_d;
  logic               wbm_cyc_q, wbm_cyc_d;
  logic               wbm_stb_q, wbm_stb_d;

  logic [LW:0]        nxt;
  logic               ld_en, ld_we;
  logic [LW-1:0]      ld_idx;
  logic [AW-1:0]      ld_base, req_base;
  logic [DW_IN-1:0]   ld_dat;
  logic [SW_IN-1:0]   ld_sel;
  logic               unused_ok;

  assign unused_ok = ^{wbs_cti_i, wbs_bte_i};
  assign req_base  = wbs_adr_i & ~(AW'(SW_IN - 1));

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    dat_d     = dat_q;
    sel_d     = sel_q;
    we_d      = we_q;
    lane_d    = lane_q;
    buf_d     = buf_q;
    hold_d    = 1'b0;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    rty_d     = 1'b0;
    wbm_adr_d = wbm_adr_q;
    wbm_dat_d = wbm_dat_q;
    wbm_sel_d = wbm_sel_q;
    wbm_we_d  = wbm_we_q;
    wbm_cyc_d = wbm_cyc_q;
    wbm_stb_d = wbm_stb_q;
    nxt       = '0;
    ld_en     = 1'b0;
    ld_we     = 1'b0;
    ld_idx    = '0;
    ld_base   = '0;
    ld_dat    = '0;
    ld_sel    = '0;

    case (state_q)
      S_IDLE: begin
        // hold_q blocks the cycle right after a response so a lingering stb is not re-taken
        if (!hold_q && wbs_cyc_i && wbs_stb_i) begin
          base_d = req_base;
          dat_d  = wbs_dat_i;
          sel_d  = wbs_sel_i;
          we_d   = wbs_we_i;
          buf_d  = '0;
          nxt    = next_lane(wbs_sel_i, 0);
          if (nxt[LW]) begin
            state_d = S_RESP;
            ack_d   = 1'b1;
          end else begin
            ld_en   = 1'b1;
            ld_idx  = nxt[LW-1:0];
            ld_base = req_base;
            ld_dat  = wbs_dat_i;
            ld_sel  = wbs_sel_i;
            ld_we   = wbs_we_i;
            state_d = S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        if (!wbs_cyc_i) begin
          wbm_cyc_d = 1'b0;
          wbm_stb_d = 1'b0;
          state_d   = S_IDLE;
        end else if (wbm_err_i || wbm_rty_i) begin
          wbm_cyc_d = 1'b0;
          wbm_stb_d = 1'b0;
          err_d     = wbm_err_i;
          rty_d     = !wbm_err_i;
          state_d   = S_RESP;
        end else if (wbm_ack_i) begin
          if (!we_q) buf_d[int'(lane_q)*DW_OUT +: DW_OUT] = wbm_dat_i;
          nxt = next_lane(sel_q, int'(lane_q) + 1);
          if (nxt[LW]) begin
            wbm_cyc_d = 1'b0;
            wbm_stb_d = 1'b0;
            ack_d     = 1'b1;
            state_d   = S_RESP;
          end else begin
            ld_en   = 1'b1;
            ld_idx  = nxt[LW-1:0];
            ld_base = base_q;
            ld_dat  = dat_q;
            ld_sel  = sel_q;
            ld_we   = we_q;
          end
        end
      end
      S_RESP: begin
        hold_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (ld_en) begin
      wbm_adr_d = ld_base + AW'(int'(ld_idx) * SW_OUT);
      wbm_dat_d = ld_dat[int'(ld_idx)*DW_OUT +: DW_OUT];
      wbm_sel_d = ld_sel[int'(ld_idx)*SW_OUT +: SW_OUT];
      wbm_we_d  = ld_we;
      wbm_cyc_d = 1'b1;
      wbm_stb_d = 1'b1;
      lane_d    = ld_idx;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q   <= S_IDLE;
      base_q    <= '0;
      dat_q     <= '0;
      sel_q     <= '0;
      we_q      <= 1'b0;
      lane_q    <= '0;
      buf_q     <= '0;
      hold_q    <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      rty_q     <= 1'b0;
      wbm_adr_q <= '0;
      wbm_dat_q <= '0;
      wbm_sel_q <= '0;
      wbm_we_q  <= 1'b0;
      wbm_cyc_q <= 1'b0;
      wbm_stb_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      dat_q     <= dat_d;
      sel_q     <= sel_d;
      we_q      <= we_d;
      lane_q    <= lane_d;
      buf_q     <= buf_d;
      hold_q    <= hold_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      rty_q     <= rty_d;
      wbm_adr_q <= wbm_adr_d;
      wbm_dat_q <= wbm_dat_d;
      wbm_sel_q <= wbm_sel_d;
      wbm_we_q  <= wbm_we_d;
      wbm_cyc_q <= wbm_cyc_d;
      wbm_stb_q <= wbm_stb_d;
    end
  end

  assign wbs_dat_o = buf_q;
  assign wbs_ack_o = ack_q;
  assign wbs_err_o = err_q;
  assign wbs_rty_o = rty_q;
  assign wbm_adr_o = wbm_adr_q;
  assign wbm_dat_o = wbm_dat_q;
  assign wbm_sel_o = wbm_sel_q;
  assign wbm_we_o  = wbm_we_q;
  assign wbm_cyc_o = wbm_cyc_q;
  assign wbm_stb_o = wbm_stb_q;
  assign wbm_cti_o = 3'b000;
  assign wbm_bte_o = 2'b00;
endmodule
